// File: rtl/alu_mux_pkg.sv
// Shared datapath width and operand-B select encoding for the ALU source mux.
package alu_mux_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ALUSRC_REG = 1'b0,
        ALUSRC_IMM = 1'b1
    } alusrc_e;

endpackage

// File: rtl/alu_mux_sat_counter.sv
// Up-counter with synchronous reset and enable that sticks at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_at_max;

    assign w_at_max = (r_count == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && !w_at_max) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/alu_mux.sv
// ALU operand-B selector: combinational RD2/immExt mux plus a registered copy
// and saturating per-source selection counters for observation.
module alu_mux
    import alu_mux_pkg::*;
#(
    parameter int WIDTH     = XLEN,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     RD2,
    input  logic [WIDTH-1:0]     immExt,
    input  logic                 aluSrc,
    output logic [WIDTH-1:0]     srcB,
    output logic [WIDTH-1:0]     srcBQ,
    output logic [CNT_WIDTH-1:0] regSelCount,
    output logic [CNT_WIDTH-1:0] immSelCount
);

    logic [WIDTH-1:0] w_srcB;
    logic             w_sel_imm;
    logic             w_sel_reg;
    logic [WIDTH-1:0] r_srcBQ;

    // Equality keeps an X/Z select propagating to srcB instead of defaulting.
    assign w_sel_imm = (aluSrc == ALUSRC_IMM);
    assign w_sel_reg = (aluSrc == ALUSRC_REG);
    assign w_srcB    = w_sel_imm ? immExt : RD2;
    assign srcB      = w_srcB;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_srcBQ <= '0;
        end else begin
            r_srcBQ <= w_srcB;
        end
    end

    assign srcBQ = r_srcBQ;

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_reg_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_sel_reg),
        .o_count(regSelCount)
    );

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_imm_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_sel_imm),
        .o_count(immSelCount)
    );

endmodule

// File: tb/tb_alu_mux.sv
// Scoreboarded random bench for alu_mux: driver queues expectations from a
// behavioural model, a negedge monitor pops and compares.
module tb_alu_mux;

    localparam int W    = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          clk_en;
    logic          reset;
    logic [W-1:0]  RD2;
    logic [W-1:0]  immExt;
    logic          aluSrc;
    logic [W-1:0]  srcB;
    logic [W-1:0]  srcBQ;
    logic [CW-1:0] regSelCount;
    logic [CW-1:0] immSelCount;

    alu_mux #(
        .WIDTH    (W),
        .CNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RD2        (RD2),
        .immExt     (immExt),
        .aluSrc     (aluSrc),
        .srcB       (srcB),
        .srcBQ      (srcBQ),
        .regSelCount(regSelCount),
        .immSelCount(immSelCount)
    );

    typedef struct {
        logic [W-1:0] b;
        logic [W-1:0] bq;
        int           rc;
        int           ic;
        bit           chk_reg;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Behavioural model state
    bit           have_state = 0;
    logic [W-1:0] m_bq = '0;
    int           m_rc = 0;
    int           m_ic = 0;
    bit           p_rst = 0;
    bit           p_src = 0;
    logic [W-1:0] p_b = '0;

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CW-1:0] act, input int req);
        n_vec++;
        if (int'(act) != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock step: fold the edge just taken into the model, apply new inputs,
    // queue what the DUT should show before the next edge.
    task automatic step(input bit rst, input bit src, input logic [W-1:0] rd2, input logic [W-1:0] imm);
        exp_t e;
        @(posedge clk);
        #1;
        if (p_rst) begin
            have_state = 1;
            m_bq = '0;
            m_rc = 0;
            m_ic = 0;
        end else if (have_state) begin
            m_bq = p_b;
            if (p_src) m_ic = (m_ic + 1 > CMAX) ? CMAX : m_ic + 1;
            else       m_rc = (m_rc + 1 > CMAX) ? CMAX : m_rc + 1;
        end
        reset  = rst;
        aluSrc = src;
        RD2    = rd2;
        immExt = imm;
        p_rst  = rst;
        p_src  = src;
        p_b    = src ? imm : rd2;
        e.b       = p_b;
        e.bq      = m_bq;
        e.rc      = m_rc;
        e.ic      = m_ic;
        e.chk_reg = have_state;
        sb_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check32("srcB", srcB, e.b);
                if (e.chk_reg) begin
                    check32("srcBQ", srcBQ, e.bq);
                    check_cnt("regSelCount", regSelCount, e.rc);
                    check_cnt("immSelCount", immSelCount, e.ic);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clk_en = 1'b0;
        reset  = 1'b0;
        aluSrc = 1'b0;
        RD2    = 32'h00BC614E;
        immExt = 32'h05397FB1;
        #1;
        check32("mux_sel0", srcB, 32'h00BC614E);
        #9;
        aluSrc = 1'b1;
        #0;
        #1;
        check32("mux_sel1", srcB, 32'h05397FB1);
        aluSrc = 1'b0;
        RD2    = 32'hFFFFFFFF;
        #1;
        check32("rd2_track", srcB, 32'hFFFFFFFF);
        immExt = 32'h12345678;
        #1;
        check32("imm_ignored", srcB, 32'hFFFFFFFF);
        p_src  = 1'b0;
        p_b    = RD2;
        clk_en = 1'b1;

        // reset, 3x imm, 2x reg
        step(1, 1, $urandom, $urandom);
        for (int i = 0; i < 3; i++) step(0, 1, $urandom, $urandom);
        for (int i = 0; i < 2; i++) step(0, 0, $urandom, $urandom);
        step(0, 1, $urandom, $urandom);
        // saturation of imm counter
        for (int i = 0; i < 20; i++) step(0, 1, $urandom, $urandom);
        // reset while counters nonzero and aluSrc=1
        step(1, 1, $urandom, 32'hA5A5_5A5A);
        step(0, 1, $urandom, 32'h0F0F_F0F0);
        // random traffic with occasional reset
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
        step(0, 0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
